mlp_axil_cfg_loader: RTL and testbench

//  AXI4-Lite master that programs one neuron of the MLP accelerator through its AXI-Lite slave.
//  On start it writes the layer and neuron select registers, then N weight words taken from a

---
 rtl/mlp_axil_cfg_loader_pkg.sv | 31 +++
 rtl/mlp_axil_cfg_loader_axil_wr_txn.sv | 88 ++++++++
 rtl/mlp_axil_cfg_loader.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mlp_axil_cfg_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_axil_cfg_loader_pkg.sv
// Shared definitions for the MLP AXI-Lite configuration loader: accelerator register offsets,
// FSM state encodings and the AXI OKAY response code.
package mlp_axil_cfg_loader_pkg;

    // Accelerator register map (byte offsets on its AXI-Lite slave)
    localparam logic [4:0] OFS_WEIGHT = 5'h00;
    localparam logic [4:0] OFS_BIAS   = 5'h04;
    localparam logic [4:0] OFS_NNOUT  = 5'h08;
    localparam logic [4:0] OFS_LAYER  = 5'h10;
    localparam logic [4:0] OFS_NEURON = 5'h14;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Load sequencer
    typedef enum logic [2:0] {
        StIdle,
        StWrLayer,
        StWrNeuron,
        StWrWeight,
        StWrBias,
        StDone
    } load_state_e;

    // Result readback channel
    typedef enum logic [1:0] {
        RdIdle,
        RdAddr,
        RdData
    } rd_state_e;

endpackage

// File: rtl/mlp_axil_cfg_loader_axil_wr_txn.sv
// Single AXI4-Lite write transaction engine. A req in idle latches addr/data; AW and W are
// raised together on the next cycle, each dropped on its own ready, and bready is raised only
// once both have been accepted. ack pulses on the B handshake with the slave's response.
module mlp_axil_cfg_loader_axil_wr_txn
    import mlp_axil_cfg_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    ack,
    output logic [1:0]              resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    logic                  active_q, active_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state: launch on req, retire each channel on its handshake, free on B
    always_comb begin
        active_d  = active_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (!active_q) begin
            if (req) begin
                active_d  = 1'b1;
                aw_pend_d = 1'b1;
                w_pend_d  = 1'b1;
                addr_d    = addr;
                data_d    = data;
            end
        end else begin
            if (aw_pend_q && awready) aw_pend_d = 1'b0;
            if (w_pend_q && wready)   w_pend_d  = 1'b0;
            if (ack)                  active_d  = 1'b0;
        end
    end

    // Transaction state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            active_q  <= active_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // Bus outputs come straight from registers so reset clears them at once
    always_comb begin
        awaddr  = addr_q;
        awprot  = 3'b000;
        awvalid = aw_pend_q;
        wdata   = data_q;
        wstrb   = '1;
        wvalid  = w_pend_q;
        bready  = active_q && !aw_pend_q && !w_pend_q;
        ack     = bready && bvalid;
        resp    = bresp;
    end

endmodule

// File: rtl/mlp_axil_cfg_loader.sv
// AXI4-Lite master that programs one MLP neuron: layer, neuron, N weights from a valid/ready
// stream, then a bias word. Optional result readback of nnOut on a rising intr edge is
// compiled in with the MLP_LOADER_READBACK_EN macro.
module mlp_axil_cfg_loader
    import mlp_axil_cfg_loader_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 5,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] REG_WEIGHT = C_M_AXI_ADDR_WIDTH'(OFS_WEIGHT),
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] REG_BIAS   = C_M_AXI_ADDR_WIDTH'(OFS_BIAS),
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] REG_NNOUT  = C_M_AXI_ADDR_WIDTH'(OFS_NNOUT),
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] REG_LAYER  = C_M_AXI_ADDR_WIDTH'(OFS_LAYER),
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] REG_NEURON = C_M_AXI_ADDR_WIDTH'(OFS_NEURON)
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic                            start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cfg_layer,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cfg_neuron,
    input  logic [15:0]                     cfg_num_weight,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wt_data,
    input  logic                            wt_valid,
    output logic                            wt_ready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic                            intr,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   res_data,
    output logic                            res_valid
);

    load_state_e                   state_q, state_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [15:0]                   num_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] layer_q, neuron_q;
    logic                          issued_q, issued_d;
    logic                          err_q, err_d;

    logic                          launch;
    logic                          rd_busy;
    logic                          rd_err;
    logic                          last_weight;

    logic                          txn_req;
    logic [C_M_AXI_ADDR_WIDTH-1:0] txn_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] txn_data;
    logic                          txn_ack;
    logic [1:0]                    txn_resp;

    // Widened so N = 65535 terminates without the counter wrapping
    assign last_weight = ({1'b0, cnt_q} + 17'd1) == {1'b0, num_q};

    // Sequencer next-state; issued_q marks that this state's write has been handed off
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        err_d    = err_q;
        txn_req  = 1'b0;
        txn_addr = REG_LAYER;
        txn_data = layer_q;
        wt_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d  = StWrLayer;
                    cnt_d    = '0;
                    issued_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            StWrLayer: begin
                txn_req = !issued_q;
                if (txn_ack) state_d = StWrNeuron;
            end
            StWrNeuron: begin
                txn_addr = REG_NEURON;
                txn_data = neuron_q;
                txn_req  = !issued_q;
                if (txn_ack) state_d = (num_q == 16'd0) ? StWrBias : StWrWeight;
            end
            StWrWeight: begin
                txn_addr = REG_WEIGHT;
                txn_data = wt_data;
                wt_ready = !issued_q;
                txn_req  = wt_ready && wt_valid;
                if (txn_ack) begin
                    if (last_weight) state_d = StWrBias;
                    else             cnt_d   = cnt_q + 16'd1;
                end
            end
            StWrBias: begin
                txn_addr = REG_BIAS;
                txn_data = wt_data;
                wt_ready = !issued_q;
                txn_req  = wt_ready && wt_valid;
                if (txn_ack) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (txn_req) issued_d = 1'b1;
        if (txn_ack) issued_d = 1'b0;
        if ((txn_ack && (txn_resp != AXI_RESP_OKAY)) || rd_err) err_d = 1'b1;
    end

    // Sequencer registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            issued_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    // Configuration captured on any start seen in idle (also while a read holds it off)
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            layer_q  <= '0;
            neuron_q <= '0;
            num_q    <= '0;
        end else if ((state_q == StIdle) && start) begin
            layer_q  <= cfg_layer;
            neuron_q <= cfg_neuron;
            num_q    <= cfg_num_weight;
        end
    end

    assign busy = (state_q != StIdle);
    assign err  = err_q;

    mlp_axil_cfg_loader_axil_wr_txn #(
        .ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
        .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
    ) u_wr_txn (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .req     (txn_req),
        .addr    (txn_addr),
        .data    (txn_data),
        .ack     (txn_ack),
        .resp    (txn_resp),
        .awaddr  (m_axi_awaddr),
        .awprot  (m_axi_awprot),
        .awvalid (m_axi_awvalid),
        .awready (m_axi_awready),
        .wdata   (m_axi_wdata),
        .wstrb   (m_axi_wstrb),
        .wvalid  (m_axi_wvalid),
        .wready  (m_axi_wready),
        .bresp   (m_axi_bresp),
        .bvalid  (m_axi_bvalid),
        .bready  (m_axi_bready)
    );

`ifdef MLP_LOADER_READBACK_EN
    rd_state_e                     rd_q, rd_d;
    logic                          intr_q;
    logic                          pend_q, pend_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                          res_valid_q, res_valid_d;
    logic                          intr_rise;
    logic                          rd_window;

    assign intr_rise = intr && !intr_q;
    assign rd_window = (state_q == StIdle) || (state_q == StDone);
    assign rd_busy   = (rd_q != RdIdle);
    // A start that lands during a read is remembered and launched once R completes
    assign launch    = (state_q == StIdle) && (start || pend_q) && !rd_busy;

    // Readback next-state: one AR to nnOut per intr rising edge outside a load
    always_comb begin
        rd_d        = rd_q;
        pend_d      = pend_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        rd_err      = 1'b0;
        unique case (rd_q)
            RdIdle: if (intr_rise && rd_window) rd_d = RdAddr;
            RdAddr: if (m_axi_arready) rd_d = RdData;
            RdData: begin
                if (m_axi_rvalid) begin
                    rd_d        = RdIdle;
                    res_data_d  = m_axi_rdata;
                    res_valid_d = 1'b1;
                    rd_err      = (m_axi_rresp != AXI_RESP_OKAY);
                end
            end
            default: rd_d = RdIdle;
        endcase
        if ((state_q == StIdle) && start && rd_busy) pend_d = 1'b1;
        if (launch) pend_d = 1'b0;
    end

    // Readback registers
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_q        <= RdIdle;
            intr_q      <= 1'b0;
            pend_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            intr_q      <= intr;
            pend_q      <= pend_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign m_axi_araddr  = REG_NNOUT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (rd_q == RdAddr);
    assign m_axi_rready  = (rd_q == RdData);
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;
`else
    logic unused_rd;

    assign unused_rd     = ^{intr, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
                             REG_NNOUT};
    assign rd_busy       = 1'b0;
    assign rd_err        = 1'b0;
    assign launch        = (state_q == StIdle) && start && !rd_busy;
    assign m_axi_araddr  = '0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
    assign res_data      = '0;
    assign res_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_axil_cfg_loader.sv
// Self-checking bench for mlp_axil_cfg_loader: a reactive AXI-Lite slave with programmable
// ready delays and error injection, a stalling weight stream, and a transaction-level model
// of the expected write list.
module tb_mlp_axil_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_layer = '0, cfg_neuron = '0;
    logic [15:0] cfg_num_weight = '0;
    logic [31:0] wt_data = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        intr = 1'b0;
    logic        busy, done, err, res_valid;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    mlp_axil_cfg_loader dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .start          (start),
        .cfg_layer      (cfg_layer),
        .cfg_neuron     (cfg_neuron),
        .cfg_num_weight (cfg_num_weight),
        .wt_data        (wt_data),
        .wt_valid       (wt_valid),
        .wt_ready       (wt_ready),
        .m_axi_awaddr   (awaddr),
        .m_axi_awprot   (awprot),
        .m_axi_awvalid  (awvalid),
        .m_axi_awready  (awready),
        .m_axi_wdata    (wdata),
        .m_axi_wstrb    (wstrb),
        .m_axi_wvalid   (wvalid),
        .m_axi_wready   (wready),
        .m_axi_bresp    (bresp),
        .m_axi_bvalid   (bvalid),
        .m_axi_bready   (bready),
        .m_axi_araddr   (araddr),
        .m_axi_arprot   (arprot),
        .m_axi_arvalid  (arvalid),
        .m_axi_arready  (arready),
        .m_axi_rdata    (rdata),
        .m_axi_rresp    (rresp),
        .m_axi_rvalid   (rvalid),
        .m_axi_rready   (rready),
        .intr           (intr),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .res_data       (res_data),
        .res_valid      (res_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- write slave ----------------
    int          aw_dly = 0, w_dly = 0, err_idx = -1, wr_base = 0;
    int          aw_wait, w_wait, wr_cnt, cyc, last_b_cyc, done_cyc, done_cnt;
    int          bready_viol, gap_viol, prot_viol, ar_seen, res_cnt;
    logic        aw_got, w_got;
    logic [4:0]  got_addr;
    logic [31:0] got_data, last_res;
    logic [4:0]  wr_a [$];
    logic [31:0] wr_d [$];

    assign awready = awvalid && !aw_got && (aw_wait >= aw_dly);
    assign wready  = wvalid && !w_got && (w_wait >= w_dly);
    assign bvalid  = aw_got && w_got;
    assign bresp   = ((wr_cnt - wr_base) == err_idx) ? 2'b10 : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_wait <= 0;
            w_wait  <= 0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; got_addr <= awaddr; aw_wait <= 0;
            end else if (awvalid && !aw_got) aw_wait <= aw_wait + 1;
            if (wvalid && wready) begin
                w_got <= 1'b1; got_data <= wdata; w_wait <= 0;
            end else if (wvalid && !w_got) w_wait <= w_wait + 1;
            if (bvalid && bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                wr_a.push_back(got_addr);
                wr_d.push_back(got_data);
                last_b_cyc <= cyc;
            end
        end
    end

    // Counters and protocol monitors (no reset, they span the whole run)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bvalid && bready) wr_cnt <= wr_cnt + 1;
        if (bready && !(aw_got && w_got)) bready_viol <= bready_viol + 1;
        if (awvalid && wt_ready) gap_viol <= gap_viol + 1;
        if ((awvalid && awprot != 3'b000) || (wvalid && wstrb != 4'hF)) prot_viol <= prot_viol + 1;
        if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
        if (arvalid) ar_seen <= ar_seen + 1;
        if (res_valid) begin res_cnt <= res_cnt + 1; last_res <= res_data; end
    end

    initial begin
        cyc = 0; wr_cnt = 0; done_cnt = 0; bready_viol = 0; gap_viol = 0; prot_viol = 0;
        ar_seen = 0; res_cnt = 0; last_b_cyc = 0; done_cyc = 0; last_res = '0;
    end

    // ---------------- read slave ----------------
`ifdef MLP_LOADER_READBACK_EN
    logic        ar_got;
    logic [4:0]  ar_addr;
    logic [31:0] rd_val = '0;
    assign arready = arvalid && !ar_got;
    assign rvalid  = ar_got;
    assign rdata   = rd_val;
    assign rresp   = 2'b00;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ar_got <= 1'b0;
        else begin
            if (arvalid && arready) begin ar_got <= 1'b1; ar_addr <= araddr; end
            if (rvalid && rready) ar_got <= 1'b0;
        end
    end
`else
    assign arready = 1'b0;
    assign rvalid  = 1'b0;
    assign rdata   = '0;
    assign rresp   = 2'b00;
`endif

    // ---------------- weight stream ----------------
    logic [31:0] smem [0:2047];
    int sp = 0, s_base = 0, s_end = 0, stall_at = -1, stall_len = 0, gap = 0;

    always @(posedge clk) begin
        int nsp, ngap;
        nsp  = sp;
        ngap = gap;
        if (wt_valid && wt_ready) begin
            nsp = sp + 1;
            if ((nsp - s_base) == stall_at) ngap = stall_len;
        end else if (gap > 0) ngap = gap - 1;
        sp       <= nsp;
        gap      <= ngap;
        wt_valid <= (nsp < s_end) && (ngap == 0);
        wt_data  <= smem[nsp & 2047];
    end

    // ---------------- one load, checked against the write-list model ----------------
    task automatic run_load(input string nm, input logic [31:0] layer, input logic [31:0] neuron,
                            input int n, input bit directed, input int e_idx,
                            input int ad, input int wd, input int st_at, input int st_len);
        logic [4:0]  ea [$];
        logic [31:0] ed [$];
        logic [31:0] w;
        int db, t, got_n;
        ea.push_back(5'h10); ed.push_back(layer);
        ea.push_back(5'h14); ed.push_back(neuron);
        @(negedge clk);
        for (int i = 0; i <= n; i++) begin
            if (i < n) w = directed ? 32'h11 * 32'(i + 1) : $urandom;
            else       w = directed ? 32'h99 : $urandom;
            ea.push_back(i < n ? 5'h00 : 5'h04);
            ed.push_back(w);
            smem[(sp + i) & 2047] = w;
        end
        s_base = sp; stall_at = st_at; stall_len = st_len; s_end = sp + n + 1;
        aw_dly = ad; w_dly = wd; err_idx = e_idx; wr_base = wr_cnt; db = done_cnt;
        cfg_layer = layer; cfg_neuron = neuron; cfg_num_weight = 16'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({nm, "_busy"}, busy, 1'b1);
        check_eq({nm, "_err_clr"}, err, 1'b0);
        t = 0;
        while (done_cnt == db && t < 3000) begin @(negedge clk); t++; end
        check_eq({nm, "_timeout"}, (t >= 3000), 1'b0);
        repeat (3) @(negedge clk);
        got_n = wr_cnt - wr_base;
        check_eq({nm, "_nwrites"}, got_n, n + 3);
        for (int i = 0; i < n + 3 && i < got_n; i++) begin
            check_eq($sformatf("%s_addr%0d", nm, i), wr_a[wr_base + i], ea[i]);
            check_eq($sformatf("%s_data%0d", nm, i), wr_d[wr_base + i], ed[i]);
        end
        check_eq({nm, "_ndone"}, done_cnt - db, 1);
        check_eq({nm, "_done_lat"}, done_cyc, last_b_cyc + 1);
        check_eq({nm, "_err"}, err, (e_idx >= 0 && e_idx < n + 3));
        check_eq({nm, "_idle"}, busy, 1'b0);
        check_eq({nm, "_bready_early"}, bready_viol, 0);
        check_eq({nm, "_aw_while_waiting"}, gap_viol, 0);
        check_eq({nm, "_prot_strb"}, prot_viol, 0);
    endtask

    initial begin
        int n, ei;
        #2;
        check_eq("reset_outs", {awvalid, wvalid, bready, arvalid, rready, wt_ready, busy, done,
                                err, res_valid, res_data}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_load("basic", 32'd1, 32'd3, 4, 1'b1, -1, 0, 0, -1, 0);
        run_load("n0", $urandom, $urandom, 0, 1'b0, -1, 0, 0, -1, 0);
        run_load("awslow", $urandom, $urandom, 3, 1'b0, -1, 3, 0, -1, 0);
        run_load("wslow", $urandom, $urandom, 3, 1'b0, -1, 0, 3, -1, 0);
        run_load("stall", $urandom, $urandom, 6, 1'b0, -1, 0, 0, 2, 5);
        run_load("bresp", $urandom, $urandom, 2, 1'b0, 1, 0, 0, -1, 0);
        repeat (10) @(negedge clk);
        check_eq("err_sticky", err, 1'b1);
        for (int k = 0; k < 6; k++) begin
            n  = $urandom_range(0, 8);
            ei = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n + 2) : -1;
            run_load($sformatf("rnd%0d", k), $urandom, $urandom, n, 1'b0, ei,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(1, n + 1), $urandom_range(0, 4));
        end

        // Result readback on an intr pulse while idle
        begin
            int rb;
            rb = res_cnt;
`ifdef MLP_LOADER_READBACK_EN
            rd_val = 32'h7;
`endif
            @(negedge clk); intr = 1'b1;
            @(negedge clk); intr = 1'b0;
            repeat (10) @(negedge clk);
`ifdef MLP_LOADER_READBACK_EN
            check_eq("rb_araddr", ar_addr, 5'h08);
            check_eq("rb_count", res_cnt - rb, 1);
            check_eq("rb_data", last_res, 32'h7);
`else
            check_eq("rb_no_ar", ar_seen, 0);
            check_eq("rb_no_res", res_cnt - rb, 0);
`endif
        end

        // Reset in the middle of a W phase drops every valid at once
        begin
            int t;
            @(negedge clk);
            smem[sp & 2047] = $urandom;
            s_base = sp; s_end = sp + 1; stall_at = -1;
            aw_dly = 0; w_dly = 1000; err_idx = -1;
            cfg_num_weight = 16'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            t = 0;
            while (!(wvalid && aw_got) && t < 100) begin @(negedge clk); t++; end
            check_eq("rst_reach_w", (t >= 100), 1'b0);
            #2 rst_n = 1'b0;
            #1 check_eq("rst_mid_w", {awvalid, wvalid, bready, arvalid, rready, wt_ready, busy},
                        '0);
            @(negedge clk);
            s_end = sp;
            rst_n = 1'b1;
            w_dly = 0;
            repeat (2) @(negedge clk);
        end
        run_load("post_rst", $urandom, $urandom, 2, 1'b0, -1, 1, 1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
